// File: rtl/mc_cu_pkg.sv
// rtl/mc_cu_pkg.sv - state, opcode, select encodings and control vector for the multi-cycle MIPS control unit
package mc_cu_pkg;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    RTYPE_EX, RTYPE_WB, SUBI_EX, IMM_WB, BRANCH, JUMP, FAULT
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_SUBI = 6'b001001;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_SUBI  = 2'b11;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iOrD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       regDst;
    logic       memToReg;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSource;
    logic       instrDone;
  } ctrl_t;

endpackage

// File: rtl/mc_cu_outdec.sv
// rtl/mc_cu_outdec.sv - combinational state to datapath control decode; JUMP decode only with MC_CU_JUMP_EN
module mc_cu_outdec
  import mc_cu_pkg::*;
(
  input  state_t state,
  input  logic   memReady,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.memRead = 1'b1;
        ctrl.aluSrcB = SRCB_FOUR;
        ctrl.aluOp   = ALUOP_ADD;
        ctrl.irWrite = memReady;
        ctrl.pcWrite = memReady;
      end
      DECODE: begin
        ctrl.aluSrcB = SRCB_IMM_SH;
        ctrl.aluOp   = ALUOP_ADD;
      end
      MEMADR: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = ALUOP_ADD;
      end
      MEMRD: begin
        ctrl.memRead = 1'b1;
        ctrl.iOrD    = 1'b1;
      end
      MEMWB: begin
        ctrl.regWrite  = 1'b1;
        ctrl.memToReg  = 1'b1;
        ctrl.instrDone = 1'b1;
      end
      MEMWR: begin
        ctrl.memWrite  = 1'b1;
        ctrl.iOrD      = 1'b1;
        ctrl.instrDone = memReady;
      end
      RTYPE_EX: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_B;
        ctrl.aluOp   = ALUOP_FUNCT;
      end
      RTYPE_WB: begin
        ctrl.regWrite  = 1'b1;
        ctrl.regDst    = 1'b1;
        ctrl.instrDone = 1'b1;
      end
      SUBI_EX: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = ALUOP_SUBI;
      end
      IMM_WB: begin
        ctrl.regWrite  = 1'b1;
        ctrl.instrDone = 1'b1;
      end
      BRANCH: begin
        ctrl.aluSrcA     = 1'b1;
        ctrl.aluSrcB     = SRCB_B;
        ctrl.aluOp       = ALUOP_SUB;
        ctrl.pcWriteCond = 1'b1;
        ctrl.pcSource    = PCSRC_ALUOUT;
        ctrl.instrDone   = 1'b1;
      end
`ifdef MC_CU_JUMP_EN
      JUMP: begin
        ctrl.pcWrite   = 1'b1;
        ctrl.pcSource  = PCSRC_JUMP;
        ctrl.instrDone = 1'b1;
      end
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multi-cycle MIPS control FSM with memory wait timeout and illegal trap; J enabled by MC_CU_JUMP_EN
module mc_control_unit
  import mc_cu_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_source,
  output logic                instr_done,
  output logic                illegal,
  output logic                timeout
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t     state, nextState;
  logic [7:0] waitCnt;
  logic       isMemState, waitExpired;
  logic       setIllegal, setTimeout;
  ctrl_t      ctrl;

  assign isMemState  = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
  // Expires on the cycle the count would reach TIMEOUT; a ready in that cycle still wins.
  assign waitExpired = isMemState && !mem_ready && ((waitCnt + 8'd1) == TIMEOUT_CNT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      waitCnt <= '0;
      illegal <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state <= nextState;
      if (nextState != state) waitCnt <= '0;
      else if (isMemState && !mem_ready) waitCnt <= waitCnt + 8'd1;
      if (setIllegal) illegal <= 1'b1;
      if (setTimeout) timeout <= 1'b1;
    end
  end

  always_comb begin
    nextState  = state;
    setIllegal = 1'b0;
    setTimeout = 1'b0;
    case (state)
      IDLE: if (run) nextState = FETCH;
      FETCH: begin
        if (mem_ready) nextState = DECODE;
        else if (waitExpired) begin
          nextState  = FAULT;
          setTimeout = 1'b1;
        end
      end
      DECODE: begin
        case (opcode)
          OP_R:         nextState = RTYPE_EX;
          OP_SUBI:      nextState = SUBI_EX;
          OP_LW, OP_SW: nextState = MEMADR;
          OP_BEQ:       nextState = BRANCH;
`ifdef MC_CU_JUMP_EN
          OP_J:         nextState = JUMP;
`endif
          default: begin
            nextState  = FAULT;
            setIllegal = 1'b1;
          end
        endcase
      end
      MEMADR:   nextState = (opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD: begin
        if (mem_ready) nextState = MEMWB;
        else if (waitExpired) begin
          nextState  = FAULT;
          setTimeout = 1'b1;
        end
      end
      MEMWR: begin
        if (mem_ready) nextState = run ? FETCH : IDLE;
        else if (waitExpired) begin
          nextState  = FAULT;
          setTimeout = 1'b1;
        end
      end
      RTYPE_EX: nextState = RTYPE_WB;
      SUBI_EX:  nextState = IMM_WB;
      MEMWB, RTYPE_WB, IMM_WB, BRANCH, JUMP: nextState = run ? FETCH : IDLE;
      FAULT:    nextState = FAULT;
      default:  nextState = IDLE;
    endcase
  end

  mc_cu_outdec u_outdec (
    .state    (state),
    .memReady (mem_ready),
    .ctrl     (ctrl)
  );

  assign pc_write      = ctrl.pcWrite;
  assign pc_write_cond = ctrl.pcWriteCond;
  assign i_or_d        = ctrl.iOrD;
  assign mem_read      = ctrl.memRead;
  assign mem_write     = ctrl.memWrite;
  assign ir_write      = ctrl.irWrite;
  assign reg_dst       = ctrl.regDst;
  assign mem_to_reg    = ctrl.memToReg;
  assign reg_write     = ctrl.regWrite;
  assign alu_src_a     = ctrl.aluSrcA;
  assign alu_src_b     = ctrl.aluSrcB;
  assign alu_op        = ctrl.aluOp;
  assign pc_source     = ctrl.pcSource;
  assign instr_done    = ctrl.instrDone;

endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - directed cycle-by-cycle check of mc_control_unit control outputs
module tb_mc_control_unit;

  logic       clk = 1'b0;
  logic       rst_n, run, mem_ready;
  logic [5:0] opcode;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, instr_done, illegal, timeout;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [18:0] obs;

  int checkCnt = 0;
  int errCnt   = 0;

  logic [18:0] vIdle, vFetch, vFetchW, vDecode, vMemAdr, vMemRd, vMemWb, vMemWr, vMemWrW;
  logic [18:0] vRtEx, vRtWb, vSubiEx, vImmWb, vBranch, vJump, vFaultIll, vFaultTo;

  always #5 clk = ~clk;

  mc_control_unit #(.OPCODE_W(6), .TIMEOUT(15)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .run           (run),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .instr_done    (instr_done),
    .illegal       (illegal),
    .timeout       (timeout)
  );

  assign obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_dst,
                mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
                instr_done, illegal, timeout};

  function automatic logic [18:0] cv(input logic pw, pwc, iod, mr, mw, irw, rd, m2r, rw, sa,
                                     input logic [1:0] sb, op, ps,
                                     input logic dn, il, to);
    return {pw, pwc, iod, mr, mw, irw, rd, m2r, rw, sa, sb, op, ps, dn, il, to};
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  // One clock cycle: apply inputs, check outputs at negedge, advance past the next posedge.
  task automatic step(input string tag, input logic rdy, input logic rn, input logic [18:0] expv);
    mem_ready = rdy;
    run       = rn;
    @(negedge clk);
    checkVal(tag, {13'd0, obs}, {13'd0, expv});
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input string tag);
    rst_n     = 1'b0;
    run       = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    checkVal(tag, {13'd0, obs}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vIdle     = '0;
    vFetch    = cv(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0,0,0);
    vFetchW   = cv(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0,0);
    vDecode   = cv(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0,0);
    vMemAdr   = cv(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,0);
    vMemRd    = cv(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0);
    vMemWb    = cv(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,1,0,0);
    vMemWr    = cv(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,1,0,0);
    vMemWrW   = cv(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0);
    vRtEx     = cv(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0,0);
    vRtWb     = cv(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,1,0,0);
    vSubiEx   = cv(0,0,0,0,0,0,0,0,0,1,2'b10,2'b11,2'b00,0,0,0);
    vImmWb    = cv(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,1,0,0);
    vBranch   = cv(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,0,0);
    vJump     = cv(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0,0);
    vFaultIll = cv(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,1,0);
    vFaultTo  = cv(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,1);

    rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0; opcode = 6'b000000;
    @(posedge clk);
    @(posedge clk);
    #1;
    doReset("reset");

    // R-type back-to-back into SUBI; run drops mid-SUBI without aborting it
    opcode = 6'b000000;
    step("r_idle", 1, 1, vIdle);
    step("r_fetch", 1, 1, vFetch);
    step("r_decode", 1, 1, vDecode);
    step("r_ex", 1, 1, vRtEx);
    step("r_wb", 1, 1, vRtWb);
    opcode = 6'b001001;
    step("subi_fetch", 1, 1, vFetch);
    step("subi_decode", 1, 0, vDecode);
    step("subi_ex", 1, 0, vSubiEx);
    step("subi_wb", 1, 0, vImmWb);
    step("subi_idle", 1, 0, vIdle);

    // LW with three wait cycles in MEMRD: eight cycles from FETCH
    opcode = 6'b100011;
    step("lw_idle", 1, 1, vIdle);
    step("lw_fetch", 1, 1, vFetch);
    step("lw_decode", 1, 1, vDecode);
    step("lw_adr", 1, 1, vMemAdr);
    for (int i = 0; i < 3; i++) step("lw_rd_wait", 0, 1, vMemRd);
    step("lw_rd", 1, 1, vMemRd);
    step("lw_wb", 1, 0, vMemWb);
    step("lw_idle_after", 1, 0, vIdle);

    // BEQ with one FETCH wait cycle
    opcode = 6'b000100;
    step("beq_idle", 0, 1, vIdle);
    step("beq_fetch_wait", 0, 1, vFetchW);
    step("beq_fetch", 1, 1, vFetch);
    step("beq_decode", 1, 1, vDecode);
    step("beq_branch", 1, 0, vBranch);
    step("beq_idle_after", 1, 1, vIdle);

    // Illegal opcode traps and holds
    opcode = 6'b111111;
    step("ill_fetch", 1, 1, vFetch);
    step("ill_decode", 1, 1, vDecode);
    for (int i = 0; i < 3; i++) step("ill_fault", 1, 1, vFaultIll);
    doReset("ill_reset");

    opcode = 6'b000010;
    step("j_idle", 1, 1, vIdle);
    step("j_fetch", 1, 1, vFetch);
    step("j_decode", 1, 1, vDecode);
`ifdef MC_CU_JUMP_EN
    step("j_jump", 1, 0, vJump);
    step("j_idle_after", 1, 0, vIdle);
`else
    step("j_fault", 1, 1, vFaultIll);
    step("j_fault_hold", 1, 1, vFaultIll);
`endif
    doReset("j_reset");

    // SW timing out after 15 wait cycles
    opcode = 6'b101011;
    step("swto_idle", 1, 1, vIdle);
    step("swto_fetch", 1, 1, vFetch);
    step("swto_decode", 1, 1, vDecode);
    step("swto_adr", 1, 1, vMemAdr);
    for (int i = 0; i < 15; i++) step("swto_wait", 0, 1, vMemWrW);
    step("swto_fault", 0, 1, vFaultTo);
    step("swto_fault_hold", 1, 1, vFaultTo);
    doReset("swto_reset");

    // Ready arriving on the 15th cycle completes normally
    step("swok_idle", 1, 1, vIdle);
    step("swok_fetch", 1, 1, vFetch);
    step("swok_decode", 1, 1, vDecode);
    step("swok_adr", 1, 1, vMemAdr);
    for (int i = 0; i < 14; i++) step("swok_wait", 0, 1, vMemWrW);
    step("swok_done", 1, 0, vMemWr);
    step("swok_idle_after", 0, 0, vIdle);

    // Reset during a pending write aborts it
    step("swrst_idle", 1, 1, vIdle);
    step("swrst_fetch", 1, 1, vFetch);
    step("swrst_decode", 1, 1, vDecode);
    step("swrst_adr", 1, 1, vMemAdr);
    step("swrst_wait", 0, 1, vMemWrW);
    doReset("swrst_reset");
    step("swrst_stay_idle", 1, 0, vIdle);
    step("swrst_stay_idle2", 1, 0, vIdle);

    $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
    $finish;
  end

endmodule
